// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer:
// funct3 opcodes, FSM state encoding and operand-signedness predicates.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic is_div(input logic [2:0] funct3);
        return (funct3 == MD_DIV) || (funct3 == MD_DIVU) ||
               (funct3 == MD_REM) || (funct3 == MD_REMU);
    endfunction

    function automatic logic op1_signed(input logic [2:0] funct3);
        return (funct3 == MD_MULH) || (funct3 == MD_MULHSU) ||
               (funct3 == MD_DIV)  || (funct3 == MD_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] funct3);
        return (funct3 == MD_MULH) || (funct3 == MD_DIV) || (funct3 == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply step or a restoring
// divide step over the {hi,lo} register pair.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_next = hi;
        lo_next = lo;
        if (is_div) begin
            shifted = {hi, lo[WIDTH-1]};
            diff    = shifted - {1'b0, operand};
            // A clear top bit means no borrow: the divisor fits, keep the difference.
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum     = lo[0] ? ({1'b0, hi} + {1'b0, operand}) : {1'b0, hi};
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer (IDLE/PREP/RUN/FIX/DONE).
// Define MULDIV_EARLY_OUT_EN to short-circuit zero operands from PREP to FIX.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_funct3,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_reg;
    logic [2:0]       funct3_reg;
    logic [WIDTH-1:0] op1_reg;
    logic [WIDTH-1:0] op2_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CW-1:0]    count_reg;
    logic             valid_reg;

    logic             div_op;
    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] fix_result;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (div_op),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .operand (operand_reg),
        .hi_next (hi_step),
        .lo_next (lo_step)
    );

    always_comb begin
        div_op = is_div(funct3_reg);
        neg1   = op1_signed(funct3_reg) & op1_reg[WIDTH-1];
        neg2   = op2_signed(funct3_reg) & op2_reg[WIDTH-1];
        abs1   = neg1 ? -op1_reg : op1_reg;
        abs2   = neg2 ? -op2_reg : op2_reg;
    end

    // Divide-by-zero and signed overflow both fall out of the unsigned core
    // plus these sign rules, so no special forcing is needed here.
    always_comb begin
        product = {hi_reg, lo_reg};
        if (neg1 ^ neg2) product = -product;
        quot = lo_reg;
        if ((neg1 ^ neg2) && (op2_reg != '0)) quot = -quot;
        rem = hi_reg;
        if (neg1) rem = -rem;
        if (div_op)
            fix_result = funct3_reg[1] ? rem : quot;
        else if (funct3_reg == MD_MUL)
            fix_result = product[WIDTH-1:0];
        else
            fix_result = product[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= S_IDLE;
            funct3_reg  <= '0;
            op1_reg     <= '0;
            op2_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            operand_reg <= '0;
            result_reg  <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
        end else if (i_flush) begin
            state_reg <= S_IDLE;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (i_valid) begin
                        funct3_reg <= i_funct3;
                        op1_reg    <= i_op1;
                        op2_reg    <= i_op2;
                        state_reg  <= S_PREP;
                    end
                end
                S_PREP: begin
                    hi_reg    <= '0;
                    count_reg <= CW'(WIDTH - 1);
                    state_reg <= S_RUN;
                    if (div_op) begin
                        lo_reg      <= abs1;
                        operand_reg <= abs2;
                    end else begin
                        lo_reg      <= abs2;
                        operand_reg <= abs1;
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    // Preload what a full run would have left so FIX needs no special case.
                    if ((op2_reg == '0) || (!div_op && (op1_reg == '0))) begin
                        state_reg <= S_FIX;
                        if (div_op) begin
                            hi_reg      <= abs1;
                            lo_reg      <= '1;
                            operand_reg <= '0;
                        end else begin
                            lo_reg <= '0;
                        end
                    end
`endif
                end
                S_RUN: begin
                    hi_reg    <= hi_step;
                    lo_reg    <= lo_step;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == '0) state_reg <= S_FIX;
                end
                S_FIX: begin
                    result_reg <= fix_result;
                    valid_reg  <= 1'b1;
                    state_reg  <= S_DONE;
                end
                S_DONE: begin
                    if (i_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign o_ready  = (state_reg == S_IDLE);
    assign o_busy   = (state_reg != S_IDLE);
    assign o_valid  = valid_reg;
    assign o_result = result_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M cases, abort paths and
// randomized operations against a 64-bit arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [2:0]  f3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] result;
    logic        busy;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid_in),
        .o_ready  (ready_out),
        .i_funct3 (f3),
        .i_op1    (op_a),
        .i_op2    (op_b),
        .i_flush  (flush),
        .o_valid  (valid_out),
        .i_ready  (ready_in),
        .o_result (result),
        .o_busy   (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Expectation handed from the driver to the compare process.
    int          issue_id = 0;
    int          done_id  = 0;
    logic [31:0] exp_res;
    int          exp_lat;
    int          cyc;
    bit          started;
    bit          seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        p  = 0;
        case (f)
            3'd0: begin p = ux * uy; return p[31:0];  end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin if (y == 0) return 32'hFFFFFFFF; p = sx / sy; return p[31:0]; end
            3'd5: begin if (y == 0) return 32'hFFFFFFFF; p = ux / uy; return p[31:0]; end
            3'd6: begin if (y == 0) return x; p = sx % sy; return p[31:0]; end
            default: begin if (y == 0) return x; p = ux % uy; return p[31:0]; end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if ((y == 0) || (!f[2] && (x == 0))) return 2;
`endif
        return 34;
    endfunction

    // Compare process: checks latency and result on every cycle o_valid is high.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_ready", {31'b0, busy}, {31'b0, !ready_out});
            if (issue_id != done_id) begin
                if (!started) begin
                    started = 1'b1;
                    seen    = 1'b0;
                    cyc     = 0;
                end else begin
                    cyc++;
                end
                if (valid_out) begin
                    if (!seen) begin
                        chk("latency", cyc, exp_lat);
                        seen = 1'b1;
                    end
                    chk("result", result, exp_res);
                    chk("ready_low_in_done", {31'b0, ready_out}, 32'd0);
                    if (ready_in) begin
                        done_id++;
                        started = 1'b0;
                    end
                end
            end else begin
                started = 1'b0;
                if (valid_out) chk("spurious_valid", {31'b0, valid_out}, 32'd0);
            end
        end
    end

    task automatic accept(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        int t;
        t = 0;
        while (!ready_out && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        f3 = f; op_a = x; op_b = y; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        f3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        chk("accepted", {31'b0, busy}, 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] req, input int hold);
        int t;
        ready_in = (hold == 0);
        accept(f, x, y);
        $display("op f3=%0d a=%h b=%h expect=%h", f, x, y, req);
        exp_res = req;
        exp_lat = lat_of(f, x, y);
        issue_id++;
        if (hold > 0) begin
            t = 0;
            while (!valid_out && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            ready_in = 1'b1;
        end
        t = 0;
        while (issue_id != done_id && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (issue_id != done_id) begin
            chk("timeout", 32'd1, 32'd0);
            issue_id = done_id;
        end
        ready_in = 1'b1;
    endtask

    task automatic quiet_window(input string name);
        bit saw;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            saw |= valid_out;
        end
        chk(name, {31'b0, saw}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;
        f3 = '0; op_a = '0; op_b = '0;
        started = 1'b0; seen = 1'b0; cyc = 0; exp_res = '0; exp_lat = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ready",  {31'b0, ready_out}, 32'd1);
        chk("reset_valid",  {31'b0, valid_out}, 32'd0);
        chk("reset_busy",   {31'b0, busy},      32'd0);
        chk("reset_result", result,             32'd0);

        run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
        run_op(3'd5, 32'd100,      32'd7,        32'd14,       0);
        run_op(3'd7, 32'd100,      32'd7,        32'd2,        0);
        run_op(3'd5, 32'h1234,     32'd0,        32'hFFFFFFFF, 0);
        run_op(3'd6, 32'h1234,     32'd0,        32'h1234,     0);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);

        // Backpressure: hold the result for 5 cycles, then expect IDLE and a fresh accept.
        run_op(3'd0, 32'd3, 32'd5, 32'd15, 5);
        chk("idle_after_take", {31'b0, ready_out}, 32'd1);
        run_op(3'd7, 32'd17, 32'd5, 32'd2, 0);

        // Flush during RUN cycle 10.
        accept(3'd0, 32'd9, 32'd9);
        repeat (10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("flush mid-run");
        chk("flush_ready", {31'b0, ready_out}, 32'd1);
        chk("flush_valid", {31'b0, valid_out}, 32'd0);
        quiet_window("flush_no_result");

        // Reset mid-RUN.
        accept(3'd4, 32'd1000, 32'd3);
        repeat (15) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset mid-run");
        chk("rst_ready",  {31'b0, ready_out}, 32'd1);
        chk("rst_busy",   {31'b0, busy},      32'd0);
        chk("rst_valid",  {31'b0, valid_out}, 32'd0);
        chk("rst_result", result,             32'd0);
        quiet_window("rst_no_result");

        // Flush together with valid in IDLE: nothing accepted.
        f3 = 3'd0; op_a = 32'd2; op_b = 32'd2; valid_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; flush = 1'b0;
        $display("flush with valid in idle");
        chk("flush_idle_ready", {31'b0, ready_out}, 32'd1);
        chk("flush_idle_busy",  {31'b0, busy},      32'd0);
        quiet_window("flush_idle_no_result");

        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom);
            ra = pick();
            rb = pick();
            run_op(rf, ra, rb, model(rf, ra, rb), ($urandom_range(0, 7) == 0) ? 3 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
